// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and handshake FSM states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_INC = 4'h2,
    OP_DEC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_ADC = 4'h7,
    OP_SBC = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_SAR = 4'hB,
    OP_ROL = 4'hC,
    OP_ROR = 4'hD,
    OP_MUL = 4'hE,
    OP_CMP = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  // prod is the accumulator including the current step, so it is final while done is high
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CntW'(1));
  assign prod = acc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CntW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CntW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath, sequential multiply, result and flags registered together.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic [WIDTH-1:0]    out_hi,
  output logic                flag_zero,
  output logic                flag_neg,
  output logic                flag_carry,
  output logic                flag_ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_state_t       state_q, state_d;
  logic             rdy_q;
  logic [WIDTH-1:0] out_q, hi_q;
  logic             z_q, n_q, c_q, v_q;

  alu_op_t            op_e;
  logic               accept, is_mul, mul_start, mul_busy, mul_done;
  logic               load_alu, load_mul;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_lo, mul_hi;

  assign op_e      = alu_op_t'(op);
  assign is_mul    = MUL_EN && (op_e == OP_MUL);
  assign in_ready  = rdy_q && !mul_busy && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign mul_lo    = mul_prod[WIDTH-1:0];
  assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH];

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (mul_start),
        .a      (in_a),
        .b      (in_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .prod   (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  logic [WIDTH:0]   a_x, bop_x, ci_x, sum;
  logic             arith, is_sub;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  // All add/subtract ops share one (WIDTH+1)-bit path; bit WIDTH is carry or borrow
  always_comb begin
    a_x    = {1'b0, in_a};
    bop_x  = {1'b0, in_b};
    ci_x   = '0;
    arith  = 1'b0;
    is_sub = 1'b0;
    sum    = '0;
    res    = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op_e)
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; ci_x = {{WIDTH{1'b0}}, c_q}; end
      OP_INC: begin arith = 1'b1; bop_x = {{WIDTH{1'b0}}, 1'b1}; end
      OP_SUB, OP_CMP: begin arith = 1'b1; is_sub = 1'b1; end
      OP_SBC: begin arith = 1'b1; is_sub = 1'b1; ci_x = {{WIDTH{1'b0}}, c_q}; end
      OP_DEC: begin arith = 1'b1; is_sub = 1'b1; bop_x = {{WIDTH{1'b0}}, 1'b1}; end
      OP_AND: res = in_a & in_b;
      OP_OR:  res = in_a | in_b;
      OP_XOR: res = in_a ^ in_b;
      OP_SHL: begin res = {in_a[WIDTH-2:0], 1'b0};      res_c = in_a[Msb]; end
      OP_SHR: begin res = {1'b0, in_a[WIDTH-1:1]};      res_c = in_a[0];   end
      OP_SAR: begin res = {in_a[Msb], in_a[WIDTH-1:1]}; res_c = in_a[0];   end
      OP_ROL: begin res = {in_a[WIDTH-2:0], in_a[Msb]}; res_c = in_a[Msb]; end
      OP_ROR: begin res = {in_a[0], in_a[WIDTH-1:1]};   res_c = in_a[0];   end
      default: ;
    endcase
    if (arith) begin
      sum   = is_sub ? (a_x - bop_x - ci_x) : (a_x + bop_x + ci_x);
      res   = sum[WIDTH-1:0];
      res_c = sum[WIDTH];
      res_v = (is_sub ? (in_a[Msb] != bop_x[Msb]) : (in_a[Msb] == bop_x[Msb]))
              && (res[Msb] != in_a[Msb]);
    end
  end

  always_comb begin
    state_d  = state_q;
    load_alu = accept && !is_mul;
    load_mul = (state_q == BUSY) && mul_done;
    case (state_q)
      IDLE: if (accept) state_d = is_mul ? BUSY : HOLD;
      BUSY: if (mul_done) state_d = HOLD;
      HOLD: begin
        if (accept) begin
          state_d = is_mul ? BUSY : HOLD;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (load_mul) begin
        out_q <= mul_lo;
        hi_q  <= mul_hi;
        z_q   <= (mul_lo == '0);
        n_q   <= mul_lo[Msb];
        c_q   <= |mul_hi;
        v_q   <= 1'b0;
      end else if (load_alu) begin
        out_q <= res;
        hi_q  <= '0;
        z_q   <= (res == '0);
        n_q   <= res[Msb];
        c_q   <= res_c;
        v_q   <= res_v;
      end
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out        = out_q;
  assign out_hi     = hi_q;
  assign flag_zero  = z_q;
  assign flag_neg   = n_q;
  assign flag_carry = c_q;
  assign flag_ovf   = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases, then randomized ops with random backpressure.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 8;
  localparam int M = 256;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, flag_zero, flag_neg, flag_carry, flag_ovf;
  logic [W-1:0] out, out_hi;

  typedef struct {
    int o;
    int hi;
    bit z, n, c, v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_wait = 0;
  bit   rnd = 1'b0;
  bit   model_c = 1'b0;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic exp_t model(input alu_op_t o, input int a, input int b, input bit cin);
    exp_t e;
    int   r, sr, sa, sb, p;
    bit   arith;
    e = '{o: 0, hi: 0, z: 0, n: 0, c: 0, v: 0};
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    arith = 1'b0;
    r = 0;
    sr = 0;
    case (o)
      OP_ADD: begin r = a + b;       sr = sa + sb;       arith = 1; e.c = (r >= M); end
      OP_ADC: begin r = a + b + cin; sr = sa + sb + cin; arith = 1; e.c = (r >= M); end
      OP_INC: begin r = a + 1;       sr = sa + 1;        arith = 1; e.c = (r >= M); end
      OP_SUB, OP_CMP: begin r = a - b; sr = sa - sb; arith = 1; e.c = (r < 0); end
      OP_SBC: begin r = a - b - cin; sr = sa - sb - cin; arith = 1; e.c = (r < 0); end
      OP_DEC: begin r = a - 1;       sr = sa - 1;        arith = 1; e.c = (r < 0); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin r = (a * 2) % M;                e.c = (a >= M / 2); end
      OP_SHR: begin r = a / 2;                      e.c = (a % 2 == 1); end
      OP_SAR: begin r = a / 2 + (a / (M / 2)) * (M / 2); e.c = (a % 2 == 1); end
      OP_ROL: begin r = (a * 2) % M + a / (M / 2);  e.c = (a >= M / 2); end
      OP_ROR: begin r = a / 2 + (a % 2) * (M / 2);  e.c = (a % 2 == 1); end
      OP_MUL: begin p = a * b; r = p % M; e.hi = p / M; e.c = (e.hi != 0); end
      default: ;
    endcase
    e.o = r & (M - 1);
    e.z = (e.o == 0);
    e.n = (e.o >= M / 2);
    e.v = arith && (sr > M / 2 - 1 || sr < -(M / 2));
    return e;
  endfunction

  // Monitor: a result is consumed on any edge where out_valid && out_ready
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", int'(out), -1);
      end else begin
        mon_e = sb_q.pop_front();
        check("out", int'(out), mon_e.o);
        check("out_hi", int'(out_hi), mon_e.hi);
        check("flag_zero", int'(flag_zero), int'(mon_e.z));
        check("flag_neg", int'(flag_neg), int'(mon_e.n));
        check("flag_carry", int'(flag_carry), int'(mon_e.c));
        check("flag_ovf", int'(flag_ovf), int'(mon_e.v));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the op
  task automatic issue(input alu_op_t o, input int a, input int b);
    exp_t e;
    int   k;
    in_valid = 1'b1;
    op = o;
    in_a = W'(a);
    in_b = W'(b);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = (k > 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
      k++;
      @(negedge clk);
    end
    last_wait = k;
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    e = model(o, a, b, model_c);
    model_c = e.c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (o == OP_MUL) begin
      for (int i = 0; i < int'(W); i++) begin
        @(negedge clk);
        check("busy_in_ready", int'(in_ready), 0);
        check("busy_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
      end
      check("mul_latency", int'(out_valid), 1);
    end else begin
      check("latency", int'(out_valid), 1);
    end
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return M - 1;
      2: return M / 2;
      3: return M / 2 - 1;
      default: return int'($urandom_range(0, M - 1));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out", int'(out), 0);
    check("rst_out_hi", int'(out_hi), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_flags", int'({flag_zero, flag_neg, flag_carry, flag_ovf}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    issue(OP_ADD, 'hFF, 'h01);
    issue(OP_ADC, 'h10, 'h20);
    issue(OP_SUB, 'h05, 'h07);
    issue(OP_SUB, 'h80, 'h01);
    issue(OP_CMP, 'h33, 'h33);
    issue(OP_MUL, 'h0F, 'h11);
    issue(OP_MUL, 'hFF, 'hFF);

    // Backpressure: result must sit still while out_ready is low
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(OP_AND, 'hF0, 'h3C);
    repeat (3) begin
      @(negedge clk);
      check("bp_out", int'(out), 'h30);
      check("bp_flags", int'({flag_zero, flag_neg, flag_carry, flag_ovf}), 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(OP_XOR, 'h0F, 'hFF);
    check("no_bubble", last_wait, 0);

    issue(OP_SHL, 'h81, 0);
    issue(OP_SAR, 'h81, 0);
    issue(OP_ROR, 'h81, 0);
    issue(OP_SHR, 'h81, 0);
    issue(OP_ROL, 'h81, 0);
    issue(OP_INC, 'h7F, 0);
    issue(OP_DEC, 'h00, 0);
    issue(OP_SBC, 'h10, 'h05);
    issue(OP_ADD, 'h12, 'h34);

    // Reset in the middle of a multiply drops it and clears every output
    in_valid = 1'b1;
    op = OP_MUL;
    in_a = 8'h0F;
    in_b = 8'h11;
    @(negedge clk);
    check("rst_mul_accept", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mrst_out", int'(out), 0);
    check("mrst_out_hi", int'(out_hi), 0);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_flags", int'({flag_zero, flag_neg, flag_carry, flag_ovf}), 0);
    check("mrst_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    model_c = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_in_ready", int'(in_ready), 1);
    issue(OP_ADD, 'h02, 'h03);
    issue(OP_ADC, 'hFF, 'h00);

    rnd = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(alu_op_t'(4'($urandom_range(0, 15))), pick(), pick());
    end
    rnd = 1'b0;
    out_ready = 1'b1;

    k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
